mem_access_unit: RTL

Memory-stage controller that consumes the EX/MEM pipeline register outputs and produces the MEM/WB register contents. It runs each load/store as a req/ack transaction against a variable-latency data memory. While a transaction is outstanding it stalls the front of the pipeline by dropping the EX/MEM enable. It flags misaligned accesses and memory timeouts.

---
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller. Runs each load/store as a req/ack
// transaction against a variable-latency data memory, stalls the front of
// the pipeline while the access is outstanding, and fills the MEM/WB register.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        iRegWrite,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iMemToReg,
    input  logic [4:0]  iRegDest,
    input  logic [31:0] iResult,
    input  logic [31:0] iB,
    input  logic [31:0] iPC,
    input  logic [31:0] iIR,
    input  logic [31:0] iRdata,
    input  logic        iAck,
    output logic        oReq,
    output logic        oWe,
    output logic [31:0] oAddr,
    output logic [31:0] oWdata,
    output logic        oStall,
    output logic        oRegWrite,
    output logic        oMemToReg,
    output logic [4:0]  oRegDest,
    output logic [31:0] oResult,
    output logic [31:0] oReadData,
    output logic [31:0] oPC,
    output logic [31:0] oIR,
    output logic        oErr,
    output logic [1:0]  oErrCode
);

    typedef enum logic [1:0] {IDLE, BUSY, COMPLETE} state_t;

    state_t      state, nextState;
    logic [7:0]  count;
    logic [31:0] capData;
    logic        timedOut;
    logic        memop, mis, startReq, ackHit, toHit;

    assign memop    = iMemRead | iMemWrite;
    assign mis      = memop & (iResult[1:0] != 2'b00);
    assign startReq = (state == IDLE) & memop & ~mis;
    // ack has priority over a timeout landing in the same cycle
    assign ackHit   = (state == BUSY) & iAck;
    assign toHit    = (state == BUSY) & ~iAck & (count == 8'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    // next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (startReq) nextState = BUSY;
            BUSY:     if (ackHit || toHit) nextState = COMPLETE;
            COMPLETE: nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // stall covers the request-issue cycle and every BUSY cycle
    always_comb begin
        oStall = startReq | (state == BUSY);
    end

    // memory request, timeout counter and captured read data
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oReq     <= 1'b0;
            oWe      <= 1'b0;
            oAddr    <= '0;
            oWdata   <= '0;
            count    <= '0;
            capData  <= '0;
            timedOut <= 1'b0;
        end else if (startReq) begin
            oReq     <= 1'b1;
            oWe      <= iMemWrite;
            oAddr    <= iResult;
            oWdata   <= iB;
            count    <= '0;
            timedOut <= 1'b0;
        end else if (ackHit) begin
            oReq    <= 1'b0;
            capData <= oWe ? 32'h0 : iRdata;
        end else if (toHit) begin
            oReq     <= 1'b0;
            capData  <= '0;
            timedOut <= 1'b1;
        end else if (state == BUSY) begin
            count <= count + 8'd1;
        end
    end

    // MEM/WB register: load when not stalled, otherwise insert a bubble
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oRegWrite <= 1'b0;
            oMemToReg <= 1'b0;
            oRegDest  <= '0;
            oResult   <= '0;
            oReadData <= '0;
            oPC       <= '0;
            oIR       <= '0;
        end else if (!oStall) begin
            oRegWrite <= iRegWrite & ~mis & ~((state == COMPLETE) & timedOut);
            oMemToReg <= iMemToReg;
            oRegDest  <= iRegDest;
            oResult   <= iResult;
            oReadData <= (state == COMPLETE) ? capData : 32'h0;
            oPC       <= iPC;
            oIR       <= iIR;
        end else begin
            oRegWrite <= 1'b0;
            oMemToReg <= 1'b0;
        end
    end

    // sticky error flag; the code records only the first error
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oErr     <= 1'b0;
            oErrCode <= 2'b00;
        end else if ((state == IDLE) && mis) begin
            oErr <= 1'b1;
            if (!oErr) oErrCode <= 2'b01;
        end else if (toHit) begin
            oErr <= 1'b1;
            if (!oErr) oErrCode <= 2'b10;
        end
    end

endmodule
